// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module dmstatus path.
// Contents: dmstatus bit positions, the 0.13 version code, and the any/all
// reduction used for every per-hart status field.
package dm_pkg;

  localparam logic [3:0] DM_VERSION_013 = 4'd2;

  localparam int unsigned DMS_IMPEBREAK       = 22;
  localparam int unsigned DMS_ALLHAVERESET    = 19;
  localparam int unsigned DMS_ANYHAVERESET    = 18;
  localparam int unsigned DMS_ALLRESUMEACK    = 17;
  localparam int unsigned DMS_ANYRESUMEACK    = 16;
  localparam int unsigned DMS_ALLNONEXISTENT  = 15;
  localparam int unsigned DMS_ANYNONEXISTENT  = 14;
  localparam int unsigned DMS_ALLUNAVAIL      = 13;
  localparam int unsigned DMS_ANYUNAVAIL      = 12;
  localparam int unsigned DMS_ALLRUNNING      = 11;
  localparam int unsigned DMS_ANYRUNNING      = 10;
  localparam int unsigned DMS_ALLHALTED       = 9;
  localparam int unsigned DMS_ANYHALTED       = 8;
  localparam int unsigned DMS_AUTHENTICATED   = 7;
  localparam int unsigned DMS_AUTHBUSY        = 6;
  localparam int unsigned DMS_HASRESETHALTREQ = 5;
  localparam int unsigned DMS_CONFSTRPTRVALID = 4;

  // Returns {all, any} of x over the selected set. Operands are zero-extended
  // to 64 bits; unused upper sel bits are 0, so ~sel there is 1 and does not
  // disturb the "all" term. An empty selection yields {0,0}.
  function automatic logic [1:0] any_all(input logic [63:0] sel,
                                         input logic [63:0] x);
    logic any_v, all_v;
    any_v = |(sel & x);
    all_v = (|sel) & (&(~sel | x));
    return {all_v, any_v};
  endfunction

endpackage

// File: rtl/dm_hart_sticky.sv
// One hart's sticky havereset / resumeack flags.
// Ports: clk_i/rst_ni clock and async active-low reset; dmactive (low holds
// resumeack clear); hart_reset / hart_resumeack set pulses from the hart;
// ack_clr / resume_clr clear pulses already qualified by hart selection;
// havereset / resumeack the flag outputs.
module dm_hart_sticky (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dmactive,
  input  logic hart_reset,
  input  logic hart_resumeack,
  input  logic ack_clr,
  input  logic resume_clr,
  output logic havereset,
  output logic resumeack
);

  // A reset event racing an acknowledge must not be lost: set wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         havereset <= 1'b1;
    else if (hart_reset) havereset <= 1'b1;
    else if (ack_clr)    havereset <= 1'b0;
  end

  // An ack arriving with a new resume request belongs to the previous
  // request, so clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             resumeack <= 1'b0;
    else if (!dmactive)      resumeack <= 1'b0;
    else if (resume_clr)     resumeack <= 1'b0;
    else if (hart_resumeack) resumeack <= 1'b1;
  end

endmodule

// File: rtl/dm_status_agg.sv
// dmstatus generator for the debug module.
// Ports: clk_i/rst_ni clock and async active-low reset; dmactive_i;
// per-hart level status (hart_halted_i/hart_running_i/hart_unavail_i) and
// event pulses (hart_reset_i/hart_resumeack_i); selection (hartsel_i,
// hasel_i, hawindow_i); command pulses (ackhavereset_i, resumereq_i);
// pass-through auth/confstr bits; dmstatus_o registered status word.
module dm_status_agg
  import dm_pkg::*;
#(
  parameter int         NHARTS          = 4,
  parameter int         HARTSEL_W       = 10,
  parameter logic [3:0] VERSION         = DM_VERSION_013,
  parameter logic       IMPEBREAK       = 1'b0,
  parameter logic       HASRESETHALTREQ = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dmactive_i,
  input  logic [NHARTS-1:0]    hart_halted_i,
  input  logic [NHARTS-1:0]    hart_running_i,
  input  logic [NHARTS-1:0]    hart_unavail_i,
  input  logic [NHARTS-1:0]    hart_reset_i,
  input  logic [NHARTS-1:0]    hart_resumeack_i,
  input  logic [HARTSEL_W-1:0] hartsel_i,
  input  logic                 hasel_i,
  input  logic [NHARTS-1:0]    hawindow_i,
  input  logic                 ackhavereset_i,
  input  logic                 resumereq_i,
  input  logic                 authenticated_i,
  input  logic                 authbusy_i,
  input  logic                 confstrptrvalid_i,
  output logic [31:0]          dmstatus_o
);

  localparam logic [31:0] RST_WORD =
    (32'(IMPEBREAK) << DMS_IMPEBREAK) |
    (32'(HASRESETHALTREQ) << DMS_HASRESETHALTREQ) |
    32'(VERSION);

  logic [NHARTS-1:0] sel, halted_e, running_e, havereset, resumeack;
  logic              nonexist;
  logic [31:0]       word;

  // Index compare is done at full 32-bit width so an out-of-range hartsel
  // never aliases onto a real hart.
  assign nonexist = 32'(hartsel_i) >= 32'(NHARTS);

  for (genvar i = 0; i < NHARTS; i++) begin : g_hart
    assign sel[i] = (32'(hartsel_i) == 32'(i)) | (hasel_i & hawindow_i[i]);
    // Unavailable dominates, then halted, then running.
    assign halted_e[i]  = hart_halted_i[i] & ~hart_unavail_i[i];
    assign running_e[i] = hart_running_i[i] & ~hart_halted_i[i] & ~hart_unavail_i[i];

    dm_hart_sticky u_sticky (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .dmactive       (dmactive_i),
      .hart_reset     (hart_reset_i[i]),
      .hart_resumeack (hart_resumeack_i[i]),
      .ack_clr        (ackhavereset_i & sel[i]),
      .resume_clr     (resumereq_i & sel[i]),
      .havereset      (havereset[i]),
      .resumeack      (resumeack[i])
    );
  end

  always_comb begin
    word = RST_WORD;
    {word[DMS_ALLHAVERESET], word[DMS_ANYHAVERESET]} = any_all(64'(sel), 64'(havereset));
    {word[DMS_ALLRESUMEACK], word[DMS_ANYRESUMEACK]} = any_all(64'(sel), 64'(resumeack));
    {word[DMS_ALLUNAVAIL],   word[DMS_ANYUNAVAIL]}   = any_all(64'(sel), 64'(hart_unavail_i));
    {word[DMS_ALLRUNNING],   word[DMS_ANYRUNNING]}   = any_all(64'(sel), 64'(running_e));
    {word[DMS_ALLHALTED],    word[DMS_ANYHALTED]}    = any_all(64'(sel), 64'(halted_e));
    word[DMS_ANYNONEXISTENT]  = nonexist;
    word[DMS_ALLNONEXISTENT]  = nonexist & ~|sel;
    word[DMS_AUTHENTICATED]   = authenticated_i;
    word[DMS_AUTHBUSY]        = authbusy_i;
    word[DMS_CONFSTRPTRVALID] = confstrptrvalid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dmstatus_o <= RST_WORD;
    else         dmstatus_o <= word;
  end

endmodule

// File: tb/tb_dm_status_agg.sv
// Randomized + directed bench for dm_status_agg with a queue scoreboard.
module tb_dm_status_agg;
  localparam int N  = 4;
  localparam int HW = 10;

  logic clk = 1'b0, rst_n = 1'b0, dmactive;
  logic [N-1:0] halted, running, unavail, hreset, hrack, hawin;
  logic [HW-1:0] hartsel;
  logic hasel, ack, rreq, auth, abusy, cfg;
  logic [31:0] dmstatus;

  dm_status_agg #(.NHARTS(N), .HARTSEL_W(HW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .hart_halted_i(halted), .hart_running_i(running), .hart_unavail_i(unavail),
    .hart_reset_i(hreset), .hart_resumeack_i(hrack), .hartsel_i(hartsel),
    .hasel_i(hasel), .hawindow_i(hawin), .ackhavereset_i(ack),
    .resumereq_i(rreq), .authenticated_i(auth), .authbusy_i(abusy),
    .confstrptrvalid_i(cfg), .dmstatus_o(dmstatus)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] exp; } sb_t;
  sb_t sbq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit m_hr[N], m_ra[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%08h want=%08h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new word; compare what is due.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_t e;
      e = sbq.pop_front();
      if (e.due == cyc) chk("scoreboard", dmstatus, e.exp);
    end
  end

  // Reference: count selected harts and how many of them show each property.
  function automatic logic [31:0] model_word();
    int ns = 0, c_hr = 0, c_ra = 0, c_u = 0, c_r = 0, c_h = 0;
    logic [31:0] w;
    bit anyn;
    for (int i = 0; i < N; i++) begin
      bit s = (int'(hartsel) == i) || (hasel && hawin[i]);
      if (s) begin
        ns++;
        if (m_hr[i]) c_hr++;
        if (m_ra[i]) c_ra++;
        if (unavail[i]) c_u++;
        else if (halted[i]) c_h++;
        else if (running[i]) c_r++;
      end
    end
    anyn = int'(hartsel) >= N;
    w = 32'h0000_0022;
    w[19] = ns > 0 && c_hr == ns;  w[18] = c_hr > 0;
    w[17] = ns > 0 && c_ra == ns;  w[16] = c_ra > 0;
    w[15] = anyn && ns == 0;       w[14] = anyn;
    w[13] = ns > 0 && c_u == ns;   w[12] = c_u > 0;
    w[11] = ns > 0 && c_r == ns;   w[10] = c_r > 0;
    w[9]  = ns > 0 && c_h == ns;   w[8]  = c_h > 0;
    w[7] = auth; w[6] = abusy; w[4] = cfg;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_hr[i] = 1; m_ra[i] = 0; end
  endtask

  // Called just after a rising edge with inputs settled: predicts the word
  // registered at the next edge, then advances the sticky model.
  task automatic step();
    sb_t e;
    e.due = cyc + 1;
    e.exp = model_word();
    sbq.push_back(e);
    for (int i = 0; i < N; i++) begin
      bit s = (int'(hartsel) == i) || (hasel && hawin[i]);
      if (hreset[i]) m_hr[i] = 1; else if (ack && s) m_hr[i] = 0;
      if (!dmactive || (rreq && s)) m_ra[i] = 0; else if (hrack[i]) m_ra[i] = 1;
    end
    @(posedge clk); #1;
    hreset = '0; hrack = '0; ack = 0; rreq = 0;
  endtask

  initial begin
    dmactive = 1; halted = '0; running = '0; unavail = '0; hreset = '0; hrack = '0;
    hawin = '0; hartsel = '0; hasel = 0; ack = 0; rreq = 0; auth = 0; abusy = 0; cfg = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_value", dmstatus, 32'h0000_0022);
    rst_n = 1;
    step();
    chk("first_cycle", dmstatus, 32'h000C_0022);
    ack = 1; step(); step();
    chk("ack_havereset", dmstatus & 32'h000C_0000, 32'h0);

    // window reductions
    hasel = 1; hawin = 4'b0101; halted = 4'b0001; step();
    chk("anyhalted_only", dmstatus & 32'h300, 32'h100);
    halted = 4'b0101; step();
    chk("allhalted", dmstatus & 32'h300, 32'h300);

    // nonexistent index
    hasel = 0; hartsel = 7; step();
    chk("nonexist_all", dmstatus & 32'hFF00, 32'hC000);
    hasel = 1; hawin = 4'b0010; step();
    chk("nonexist_any", dmstatus & 32'hC000, 32'h4000);

    // resume handshake on hart 2
    hasel = 0; hartsel = 2; halted = '0; rreq = 1; step();
    step(); step();
    hrack = 4'b0100; step(); step();
    chk("resumeack_set", dmstatus & 32'h30000, 32'h30000);
    rreq = 1; hrack = 4'b0100; step(); step();
    chk("resumeack_clr_wins", dmstatus & 32'h30000, 32'h0);

    // reset beats ack
    hartsel = 1; hreset = 4'b0010; ack = 1; step(); step();
    chk("havereset_set_wins", dmstatus & 32'h40000, 32'h40000);

    // dmactive low drops resumeack, keeps havereset
    hartsel = 3; hrack = 4'b1000; step();
    dmactive = 0; step(); step();
    chk("dmactive_clr", dmstatus & 32'h70000, 32'h40000);
    dmactive = 1;

    // randomized phase with one async reset in the middle
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        #2 rst_n = 0;
        #1 chk("async_reset", dmstatus, 32'h0000_0022);
        sbq.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
      end
      if ($urandom_range(0, 3) == 0) halted  = N'($urandom);
      if ($urandom_range(0, 3) == 0) running = N'($urandom);
      if ($urandom_range(0, 7) == 0) unavail = N'($urandom);
      hartsel  = HW'($urandom_range(0, 6));
      hasel    = $urandom_range(0, 1) == 1;
      hawin    = N'($urandom);
      hreset   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      hrack    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      ack      = $urandom_range(0, 4) == 0;
      rreq     = $urandom_range(0, 4) == 0;
      dmactive = $urandom_range(0, 15) != 0;
      auth = 1'($urandom); abusy = 1'($urandom); cfg = 1'($urandom);
      step();
    end
    @(posedge clk); @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dm_status_agg.md
Name: dm_status_agg

Overview:
Parametrised dmstatus generator for the RISC-V debug module, serving NHARTS harts.
- Tracks per-hart sticky havereset and resumeack state.
- Applies hart selection (hartsel plus an optional hart-array window) and reduces per-hart status into the any*/all* fields.
- Drives a registered 32-bit dmstatus word to the DMI register file.

Parameters:
NHARTS, 4, number of harts tracked (1..64)
HARTSEL_W, 10, width of hartsel_i
VERSION, 4'd2, dmstatus.version (2 = debug spec 0.13)
IMPEBREAK, 1'b0, dmstatus.impebreak constant
HASRESETHALTREQ, 1'b1, dmstatus.hasresethaltreq constant

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
dmactive_i  in  1  dmcontrol.dmactive; low clears resumeack state
hart_halted_i  in  NHARTS  per-hart halted level
hart_running_i  in  NHARTS  per-hart running level
hart_unavail_i  in  NHARTS  per-hart unavailable level
hart_reset_i  in  NHARTS  per-hart one-cycle pulse: hart left reset
hart_resumeack_i  in  NHARTS  per-hart one-cycle pulse: hart resumed
hartsel_i  in  HARTSEL_W  selected hart index
hasel_i  in  1  hart-array mode enable
hawindow_i  in  NHARTS  hart-array mask
ackhavereset_i  in  1  pulse: clear havereset of selected harts
resumereq_i  in  1  pulse: new resume request to selected harts
authenticated_i  in  1  passed through to bit 7
authbusy_i  in  1  passed through to bit 6
confstrptrvalid_i  in  1  passed through to bit 4
dmstatus_o  out  32  registered dmstatus word

Behaviour:
- Selection (combinational): sel[i] = (hartsel_i == i) | (hasel_i & hawindow_i[i]). hartsel_i >= NHARTS selects no hart by index.
- Effective per-hart state, with this priority:
  - unavail_e = unavail.
  - halted_e = halted & ~unavail.
  - running_e = running & ~halted & ~unavail. Halted wins over running when both are asserted.
- Sticky havereset[i]:
  - Reset value 1.
  - Set by hart_reset_i[i].
  - Cleared by ackhavereset_i & sel[i].
  - Set wins over clear in the same cycle.
  - Not affected by dmactive_i.
- Sticky resumeack[i]:
  - Reset value 0.
  - Set by hart_resumeack_i[i].
  - Cleared by resumereq_i & sel[i].
  - Clear wins over set in the same cycle: that ack belongs to the old request.
  - Held at 0 while dmactive_i is low.
- Reductions for field X over the selected set S:
  - anyX = |(sel & X).
  - allX = (|sel) & &(~sel | X).
  - If no hart is selected, all any*/all* fields are 0, except the nonexistent fields below.
- Nonexistent fields:
  - anynonexistent = (hartsel_i >= NHARTS).
  - allnonexistent = anynonexistent & ~|sel.
- Bit map: [31:23]=0, [22]=IMPEBREAK, [21:20]=0, [19] allhavereset, [18] anyhavereset, [17] allresumeack, [16] anyresumeack, [15] allnonexistent, [14] anynonexistent, [13] allunavail, [12] anyunavail, [11] allrunning, [10] anyrunning, [9] allhalted, [8] anyhalted, [7] authenticated_i, [6] authbusy_i, [5] HASRESETHALTREQ, [4] confstrptrvalid_i, [3:0] VERSION.
- Latency:
  - dmstatus_o is registered from current inputs and current sticky state.
  - Level inputs and selection changes are visible 1 cycle later.
  - Pulse events (reset, resumeack, ack, resumereq) are visible 2 cycles later: one edge to update the sticky bit, one to register the output.
- Reset:
  - dmstatus_o = constant fields only (IMPEBREAK, HASRESETHALTREQ, VERSION), all other bits 0.
  - Sticky state takes its reset values.
  - Reset asserted mid-operation discards pending pulses immediately, asynchronously.

Decomposition:
- dm_pkg: bit-position localparams for every dmstatus field, DM_VERSION_013 = 4'd2, and a function for the any/all reduction.
- Sub-module dm_hart_sticky: holds one hart's havereset/resumeack flops with the set/clear priority rules; instantiated NHARTS times in a generate loop.

Test Plan:
- Reset release, NHARTS=4, hartsel=0 -> cycle 1: dmstatus_o = 0x000C_0022 (havereset set, version 2, hasresethaltreq); after ackhavereset_i pulse, bits 19:18 = 0 two cycles later.
- hasel=1, hawindow=4'b0101, halted=4'b0001 -> anyhalted=1, allhalted=0; set halted=4'b0101 -> allhalted=1 next cycle.
- hartsel=7, hasel=0 -> bits 15:14 = 2'b11, bits 13:8 = 0; hasel=1, hawindow=4'b0010 -> bit14=1, bit15=0.
- resumereq_i on hart 2, then hart_resumeack_i[2] 3 cycles later -> bits 17:16 go 0 then 2'b11; resumereq_i coincident with resumeack pulse -> bits stay 0.
- hart_reset_i[1] coincident with ackhavereset_i, hartsel=1 -> havereset[1] stays 1 (bit 18 = 1).
- dmactive_i=0 with resumeack set -> bits 17:16 = 0 within 2 cycles; havereset bits unchanged; async rst_ni mid-burst -> output returns to the reset value with no clock edge.
